viterbi_acs_array: RTL and testbench



---
 rtl/viterbi_pkg.sv | 19 +
 rtl/viterbi_acs_array_if.sv | 23 ++
 rtl/viterbi_acs_array_acs_cell.sv | 22 ++
 rtl/viterbi_acs_array.sv | 103 ++++++++++
 tb/tb_viterbi_acs_array.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3, rate-1/2 (generators 7,5) Viterbi decoder.
// Holds the trellis constants and the encoder output map.
package viterbi_pkg;

    localparam int NUM_STATES  = 4;
    localparam int K           = 3;
    localparam int PM_W_DEF    = 6;
    localparam int PM_INIT_DEF = 16;

    // Returns {out0,out1} for the branch leaving state {s1,s0} on input u.
    function automatic logic [1:0] code_sym(input logic [1:0] state, input logic u);
        logic out0;
        logic out1;
        out0 = u ^ state[1] ^ state[0];
        out1 = u ^ state[0];
        return {out0, out1};
    endfunction

endpackage

// File: rtl/viterbi_acs_array_if.sv
// Branch-metric input and decision output bundle of the ACS array.
// The source of branch metrics drives through master; the ACS array is the slave.
interface viterbi_acs_array_if #(
    parameter int PM_W = viterbi_pkg::PM_W_DEF
);
    logic                start;
    logic                bm_valid;
    logic [7:0]          bm_in;
    logic                dec_valid;
    logic [3:0]          dec_out;
    logic [1:0]          best_state;
    logic [4*PM_W-1:0]   pm_out;

    modport master (
        output start, bm_valid, bm_in,
        input  dec_valid, dec_out, best_state, pm_out
    );

    modport slave (
        input  start, bm_valid, bm_in,
        output dec_valid, dec_out, best_state, pm_out
    );
endinterface

// File: rtl/viterbi_acs_array_acs_cell.sv
// One add-compare-select butterfly half: two candidate costs, pick the smaller.
// Ties favour the predecessor with s0 = 0 (pm_a).
module acs_cell #(
    parameter int PM_W = 6
) (
    input  logic [PM_W-1:0] pm_a,
    input  logic [PM_W-1:0] pm_b,
    input  logic [1:0]      bm_a,
    input  logic [1:0]      bm_b,
    output logic [PM_W:0]   sel,
    output logic            dec
);
    logic [PM_W:0] cand_a;
    logic [PM_W:0] cand_b;

    always_comb begin
        cand_a = {1'b0, pm_a} + {{(PM_W-1){1'b0}}, bm_a};
        cand_b = {1'b0, pm_b} + {{(PM_W-1){1'b0}}, bm_b};
        dec    = (cand_b < cand_a);
        sel    = dec ? cand_b : cand_a;
    end
endmodule

// File: rtl/viterbi_acs_array.sv
// Four-state ACS array: updates path metrics, emits survivor decisions, tracks
// the best state and rescales metrics once all of them reach the upper half.
module viterbi_acs_array
    import viterbi_pkg::*;
#(
    parameter int PM_W    = PM_W_DEF,
    parameter int PM_INIT = PM_INIT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    viterbi_acs_array_if.slave  acs
);
    localparam logic [PM_W:0] HALF = (PM_W+1)'(2**(PM_W-1));

    logic [NUM_STATES-1:0][PM_W-1:0] pm_q, pm_d;
    logic [NUM_STATES-1:0][PM_W-1:0] pm_init, pm_old, pm_new;
    logic [NUM_STATES-1:0][PM_W:0]   sel;
    logic [NUM_STATES-1:0]           dec;
    logic [NUM_STATES-1:0]           dec_q, dec_d;
    logic [1:0]                      best_q, best_d, best;
    logic                            dec_valid_q, dec_valid_d;
    logic                            norm;

    // Next state n = {n1,n0}: predecessors {n0,0} and {n0,1}, input bit u = n1.
    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic [1:0] PA    = 2'((n % 2) * 2);
        localparam logic [1:0] PB    = 2'((n % 2) * 2 + 1);
        localparam logic       U     = 1'(n / 2);
        localparam int         SYM_A = int'(code_sym(PA, U));
        localparam int         SYM_B = int'(code_sym(PB, U));

        acs_cell #(.PM_W(PM_W)) u_acs (
            .pm_a (pm_old[PA]),
            .pm_b (pm_old[PB]),
            .bm_a (acs.bm_in[2*SYM_A +: 2]),
            .bm_b (acs.bm_in[2*SYM_B +: 2]),
            .sel  (sel[n]),
            .dec  (dec[n])
        );
    end

    always_comb begin
        pm_init[0] = '0;
        for (int i = 1; i < NUM_STATES; i++) begin
            pm_init[i] = PM_W'(PM_INIT);
        end
        pm_old = acs.start ? pm_init : pm_q;

        // Clearing the top bit of every metric at once keeps all differences intact.
        norm = 1'b1;
        for (int i = 0; i < NUM_STATES; i++) begin
            norm = norm & (sel[i] >= HALF);
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_new[i] = norm ? PM_W'(sel[i] - HALF) : PM_W'(sel[i]);
        end

        best = 2'd0;
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_new[i] < pm_new[best]) begin
                best = 2'(i);
            end
        end
    end

    always_comb begin
        pm_d        = pm_q;
        dec_d       = dec_q;
        best_d      = best_q;
        dec_valid_d = 1'b0;
        if (acs.bm_valid) begin
            pm_d        = pm_new;
            dec_d       = dec;
            best_d      = best;
            dec_valid_d = 1'b1;
        end else if (acs.start) begin
            pm_d = pm_init;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pm_q[0]     <= '0;
            pm_q[1]     <= PM_W'(PM_INIT);
            pm_q[2]     <= PM_W'(PM_INIT);
            pm_q[3]     <= PM_W'(PM_INIT);
            dec_q       <= '0;
            best_q      <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            pm_q        <= pm_d;
            dec_q       <= dec_d;
            best_q      <= best_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign acs.dec_valid  = dec_valid_q;
    assign acs.dec_out    = dec_q;
    assign acs.best_state = best_q;
    assign acs.pm_out     = pm_q;

endmodule

// File: tb/tb_viterbi_acs_array.sv
// Randomized and directed bench for the ACS array against a forward-trellis model.
module tb_viterbi_acs_array;
    localparam int PM_W    = 6;
    localparam int PM_INIT = 16;
    localparam int HALF    = 1 << (PM_W - 1);

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    int   m_pm[4];
    int   m_dec;
    int   m_best;
    int   m_dv;

    viterbi_acs_array_if #(.PM_W(PM_W)) vif ();

    viterbi_acs_array #(.PM_W(PM_W), .PM_INIT(PM_INIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .acs   (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int dut_pm(input int n);
        logic [4*PM_W-1:0] v;
        v = vif.pm_out;
        return int'(v[n*PM_W +: PM_W]);
    endfunction

    // Distances of received pair rx = {r0,r1} to every code symbol {out0,out1}.
    function automatic logic [7:0] bm_for(input logic [1:0] rx);
        logic [7:0] bm;
        logic [1:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 2'(i) ^ rx;
            bm[2*i +: 2] = 2'(int'(d[0]) + int'(d[1]));
        end
        return bm;
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = PM_INIT;
        m_dec  = 0;
        m_best = 0;
        m_dv   = 0;
    endtask

    // Forward pass over every (state, input) edge; strict '<' keeps the even predecessor on ties.
    task automatic model_step(input logic s, input logic v, input logic [7:0] bm);
        int old[4];
        int nw[4];
        int u, st, nx, o0, o1, c, dsel;
        if (!v) begin
            if (s) begin
                m_pm[0] = 0;
                for (int i = 1; i < 4; i++) m_pm[i] = PM_INIT;
            end
            m_dv = 0;
            return;
        end
        for (int i = 0; i < 4; i++) begin
            old[i] = s ? ((i == 0) ? 0 : PM_INIT) : m_pm[i];
            nw[i]  = 1 << 30;
        end
        dsel = 0;
        for (st = 0; st < 4; st++) begin
            for (u = 0; u < 2; u++) begin
                nx = u * 2 + st / 2;
                o0 = u ^ (st / 2) ^ (st % 2);
                o1 = u ^ (st % 2);
                c  = old[st] + int'(bm[2*(o0*2+o1) +: 2]);
                if (c < nw[nx]) begin
                    nw[nx] = c;
                    if (st % 2 == 1) dsel = dsel | (1 << nx);
                    else             dsel = dsel & ~(1 << nx);
                end
            end
        end
        if (nw[0] >= HALF && nw[1] >= HALF && nw[2] >= HALF && nw[3] >= HALF) begin
            for (int i = 0; i < 4; i++) nw[i] -= HALF;
        end
        m_best = 0;
        for (int i = 0; i < 4; i++) begin
            m_pm[i] = nw[i];
            if (nw[i] < nw[m_best]) m_best = i;
        end
        m_dec = dsel;
        m_dv  = 1;
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".dv"}, int'(vif.dec_valid), m_dv);
        check_val({tag, ".dec"}, int'(vif.dec_out), m_dec);
        check_val({tag, ".best"}, int'(vif.best_state), m_best);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s.pm%0d", tag, i), dut_pm(i), m_pm[i]);
        end
    endtask

    task automatic drive(input string tag, input logic s, input logic v, input logic [7:0] bm);
        @(negedge clk);
        vif.start    = s;
        vif.bm_valid = v;
        vif.bm_in    = bm;
        @(posedge clk);
        #1;
        model_step(s, v, bm);
        compare_all(tag);
    endtask

    task automatic encode_run(input string tag, input bit flip);
        logic [1:0] st;
        logic [1:0] rx;
        logic       u;
        int         bits[6] = '{1, 0, 1, 1, 0, 0};
        st = 2'd0;
        for (int k = 0; k < 6; k++) begin
            u  = 1'(bits[k]);
            rx = {u ^ st[1] ^ st[0], u ^ st[0]};
            if (flip && k == 2) rx = rx ^ 2'b10;
            st = {u, st[1]};
            drive($sformatf("%s%0d", tag, k), k == 0, 1'b1, bm_for(rx));
            if (!flip) begin
                check_val($sformatf("%s%0d.true_best", tag, k), int'(vif.best_state), int'(st));
                check_val($sformatf("%s%0d.true_pm", tag, k), dut_pm(int'(st)), 0);
            end
        end
        if (flip) begin
            check_val({tag, ".final_best"}, int'(vif.best_state), 0);
            check_val({tag, ".final_pm"}, dut_pm(0), 1);
        end
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        vif.start    = 1'b0;
        vif.bm_valid = 1'b0;
        vif.bm_in    = '0;
        rst_n        = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First step after reset with rx = 00.
        drive("rx00", 1'b0, 1'b1, 8'b10_01_01_00);
        check_val("rx00.pm1_abs", dut_pm(1), 17);
        check_val("rx00.pm2_abs", dut_pm(2), 2);
        drive("rx00_idle", 1'b0, 1'b0, 8'h00);

        encode_run("enc", 1'b0);
        encode_run("err", 1'b1);

        // Every branch costs 2: metrics climb until the common MSB is cleared.
        for (int k = 0; k < 40; k++) begin
            drive($sformatf("norm%0d", k), k == 0, 1'b1, 8'b10_10_10_10);
            check_val($sformatf("norm%0d.nowrap", k), int'(dut_pm(0) < 2 * HALF - 2), 1);
        end

        // Asynchronous reset mid-stream, then start with valid.
        drive("pre_rst", 1'b0, 1'b1, bm_for(2'b01));
        vif.start    = 1'b0;
        vif.bm_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        drive("post_rst", 1'b1, 1'b1, 8'b10_01_01_00);
        check_val("post_rst.pm1_abs", dut_pm(1), 17);

        // Gapped valid and start without valid.
        drive("gap0", 1'b0, 1'b1, bm_for(2'b11));
        drive("gap1", 1'b0, 1'b0, bm_for(2'b10));
        drive("gap2", 1'b0, 1'b0, bm_for(2'b01));
        drive("gap3", 1'b0, 1'b1, bm_for(2'b10));
        drive("start_only", 1'b1, 1'b0, bm_for(2'b11));
        check_val("start_only.pm3_abs", dut_pm(3), PM_INIT);
        drive("after_start", 1'b0, 1'b1, 8'b10_01_01_00);

        // Randomized traffic.
        for (int k = 0; k < 200; k++) begin
            logic s;
            logic v;
            s = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) != 0);
            drive($sformatf("rnd%0d", k), s, v, bm_for(2'($urandom_range(0, 3))));
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule
